// File: rtl/dco_cal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dco_cal_ctrl
// Purpose  : 5-step successive-approximation coarse calibration of dco_5bit's
//            threshold code, then hands ctrl/ctrl_sign to the loop filter.
//            Optional lock monitor enabled by defining DCO_CAL_LOCKMON_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dco_cal_ctrl #(
    parameter int WIN_LEN = 255,
    parameter int SETTLE  = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic             dco_clk,
    input  logic [4:0]       kdco_cfg,
    input  logic [4:0]       offset_cfg,
    input  logic [4:0]       lf_ctrl,
    input  logic             lf_sign,
    output logic [4:0]       thresh_val,
    output logic [4:0]       kdco,
    output logic [4:0]       dco_offset,
    output logic [4:0]       ctrl,
    output logic             ctrl_sign,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             lock_lost
);

    localparam int TMR_MAX = (WIN_LEN > SETTLE) ? WIN_LEN : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] c_win_last    = TMR_W'(WIN_LEN - 1);
    localparam logic [TMR_W-1:0] c_settle_last = TMR_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_LOCK    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [2:0]       r_bit_idx;
    logic             r_dco_q;
    logic             w_edge;
    logic             w_tmr_zero;
    logic             w_start_ok;
    logic [4:0]       w_bit_mask;
    logic [4:0]       w_code;

    assign w_edge     = dco_clk & ~r_dco_q;
    assign w_cnt_inc  = (w_edge && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_tmr_zero = (r_tmr == '0);
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_LOCK));
    assign w_bit_mask = 5'b00001 << r_bit_idx;

    assign busy = (r_state == ST_SETTLE) || (r_state == ST_MEASURE) || (r_state == ST_DECIDE);
    assign done = (r_state == ST_LOCK);

    // Trial bit is dropped when the DCO came out too slow; next lower bit is tried.
    always_comb begin
        w_code = thresh_val;
        if (r_cnt < target_cnt) begin
            w_code = w_code & ~w_bit_mask;
        end
        if (r_bit_idx != 3'd0) begin
            w_code = w_code | (w_bit_mask >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_SETTLE;
            ST_SETTLE:  if (w_tmr_zero) w_state_nxt = ST_MEASURE;
            ST_MEASURE: if (w_tmr_zero) w_state_nxt = ST_DECIDE;
            ST_DECIDE:  w_state_nxt = (r_bit_idx != 3'd0) ? ST_SETTLE : ST_LOCK;
            ST_LOCK:    if (start) w_state_nxt = ST_SETTLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_val <= 5'd16;
            kdco       <= '0;
            dco_offset <= '0;
            meas_cnt   <= '0;
            r_tmr      <= '0;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd4;
            r_dco_q    <= 1'b0;
        end else begin
            r_dco_q <= dco_clk;
            if (w_start_ok) begin
                kdco       <= kdco_cfg;
                dco_offset <= offset_cfg;
                thresh_val <= 5'b10000;
                r_bit_idx  <= 3'd4;
                r_tmr      <= c_settle_last;
            end else begin
                case (r_state)
                    ST_SETTLE: begin
                        if (w_tmr_zero) begin
                            r_tmr <= c_win_last;
                            r_cnt <= '0;
                        end else begin
                            r_tmr <= r_tmr - TMR_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        r_cnt <= w_cnt_inc;
                        if (!w_tmr_zero) r_tmr <= r_tmr - TMR_W'(1);
                    end
                    ST_DECIDE: begin
                        meas_cnt   <= r_cnt;
                        thresh_val <= w_code;
                        if (r_bit_idx != 3'd0) begin
                            r_bit_idx <= r_bit_idx - 3'd1;
                            r_tmr     <= c_settle_last;
                        end else begin
                            r_tmr <= c_win_last;
                            r_cnt <= '0;
                        end
                    end
`ifdef DCO_CAL_LOCKMON_EN
                    ST_LOCK: begin
                        if (w_tmr_zero) begin
                            meas_cnt <= w_cnt_inc;
                            r_cnt    <= '0;
                            r_tmr    <= c_win_last;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            r_tmr <= r_tmr - TMR_W'(1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Loop filter drives the DCO only while the loop stays closed.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl      <= '0;
            ctrl_sign <= 1'b0;
        end else if ((r_state == ST_LOCK) && (w_state_nxt == ST_LOCK)) begin
            ctrl      <= lf_ctrl;
            ctrl_sign <= lf_sign;
        end else begin
            ctrl      <= '0;
            ctrl_sign <= 1'b0;
        end
    end

`ifdef DCO_CAL_LOCKMON_EN
    logic [CNT_W-1:0] w_diff;
    logic             r_lock_lost;

    assign w_diff    = (w_cnt_inc >= target_cnt) ? (w_cnt_inc - target_cnt) : (target_cnt - w_cnt_inc);
    assign lock_lost = r_lock_lost;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_lost <= 1'b0;
        end else if (w_start_ok) begin
            r_lock_lost <= 1'b0;
        end else if ((r_state == ST_LOCK) && w_tmr_zero && (w_diff > CNT_W'(2))) begin
            r_lock_lost <= 1'b1;
        end
    end
`else
    assign lock_lost = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dco_cal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dco_cal_ctrl
// Purpose  : Self-checking bench for dco_cal_ctrl with a periodic DCO stub and
//            a search-result reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dco_cal_ctrl;

    localparam int WIN  = 255;
    localparam int TRL  = 260;
    localparam int DONE_CYC = 1301;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] target_cnt = 8'd0;
    logic       dco_clk = 1'b0;
    logic [4:0] kdco_cfg = '0;
    logic [4:0] offset_cfg = '0;
    logic [4:0] lf_ctrl = '0;
    logic       lf_sign = 1'b0;
    logic [4:0] thresh_val, kdco, dco_offset, ctrl;
    logic       ctrl_sign, busy, done, lock_lost;
    logic [7:0] meas_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int ph = 0;
    int n_override = -1;

    dco_cal_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .target_cnt(target_cnt),
        .dco_clk(dco_clk), .kdco_cfg(kdco_cfg), .offset_cfg(offset_cfg),
        .lf_ctrl(lf_ctrl), .lf_sign(lf_sign), .thresh_val(thresh_val),
        .kdco(kdco), .dco_offset(dco_offset), .ctrl(ctrl), .ctrl_sign(ctrl_sign),
        .busy(busy), .done(done), .meas_cnt(meas_cnt), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    // Period-WIN pattern with N isolated pulses: any WIN-cycle window sees exactly N edges.
    always @(negedge clk) begin
        int n;
        ph = (ph == WIN - 1) ? 0 : ph + 1;
        n  = (n_override >= 0) ? n_override : edges_for(int'(thresh_val));
        dco_clk = (ph < 2 * n) && (ph % 2 == 0);
    end

    function automatic int edges_for(input int code);
        return 100 - 3 * code;
    endfunction

    function automatic int model_result(input int tgt);
        for (int c = 31; c >= 0; c--) begin
            if (edges_for(c) >= tgt) return c;
        end
        return 0;
    endfunction

    function automatic int trial_code(input int res, input int b);
        return (res & ~((1 << (b + 1)) - 1)) | (1 << b);
    endfunction

    task automatic run_search(input int tgt, input bit inject);
        int res, exp_meas;
        logic [4:0] kc, oc;
        bit ctrl_bad;
        res      = model_result(tgt);
        exp_meas = edges_for(trial_code(res, 0));
        kc = 5'($urandom);
        oc = 5'($urandom);
        ctrl_bad = 1'b0;
        @(negedge clk);
        target_cnt = 8'(tgt);
        kdco_cfg   = kc;
        offset_cfg = oc;
        start      = 1'b1;
        for (int cyc = 1; cyc <= DONE_CYC; cyc++) begin
            @(posedge clk);
            #1;
            start   = inject && (cyc == 500);
            lf_ctrl = 5'($urandom);
            lf_sign = 1'($urandom);
            if (ctrl !== 5'd0 || ctrl_sign !== 1'b0) ctrl_bad = 1'b1;
            if (cyc == 1) begin
                n_tests++;
                if (busy !== 1'b1 || done !== 1'b0 || thresh_val !== 5'd16 || lock_lost !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_response tgt=%0d: busy=%b done=%b thresh=%0d lock_lost=%b, required 1 0 16 0",
                             tgt, busy, done, thresh_val, lock_lost);
                end
            end
            if (cyc % TRL == 0) begin
                n_tests++;
                if (thresh_val !== 5'(trial_code(res, 5 - cyc / TRL))) begin
                    n_fail++;
                    $display("FAIL trial_code tgt=%0d cyc=%0d: got %0d, required %0d",
                             tgt, cyc, thresh_val, trial_code(res, 5 - cyc / TRL));
                end
            end
            if (cyc == DONE_CYC - 1) begin
                n_tests++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_early tgt=%0d: busy=%b done=%b, required 1 0", tgt, busy, done);
                end
            end
            if (cyc == DONE_CYC) begin
                n_tests++;
                if (busy !== 1'b0 || done !== 1'b1 || thresh_val !== 5'(res) || meas_cnt !== 8'(exp_meas)
                    || kdco !== kc || dco_offset !== oc) begin
                    n_fail++;
                    $display("FAIL lock_result tgt=%0d: busy=%b done=%b thresh=%0d meas=%0d kdco=%0d off=%0d, required 0 1 %0d %0d %0d %0d",
                             tgt, busy, done, thresh_val, meas_cnt, kdco, dco_offset, res, exp_meas, kc, oc);
                end
            end
        end
        n_tests++;
        if (ctrl_bad) begin
            n_fail++;
            $display("FAIL ctrl_open_loop tgt=%0d: ctrl nonzero during calibration, required 0", tgt);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (thresh_val !== 5'd16 || kdco !== 5'd0 || dco_offset !== 5'd0 || ctrl !== 5'd0 || ctrl_sign !== 1'b0
            || busy !== 1'b0 || done !== 1'b0 || meas_cnt !== 8'd0 || lock_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: thresh=%0d kdco=%0d off=%0d ctrl=%0d sign=%b busy=%b done=%b meas=%0d ll=%b, required 16 0 0 0 0 0 0 0 0",
                     thresh_val, kdco, dco_offset, ctrl, ctrl_sign, busy, done, meas_cnt, lock_lost);
        end
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_nominal();
        run_search(55, 1'b0);
        n_tests++;
        if (thresh_val !== 5'd15 || meas_cnt !== 8'd55) begin
            n_fail++;
            $display("FAIL nominal_final: thresh=%0d meas=%0d, required 15 55", thresh_val, meas_cnt);
        end
    endtask

    task automatic test_extremes();
        run_search(0, 1'b0);
        n_tests++;
        if (thresh_val !== 5'd31) begin
            n_fail++;
            $display("FAIL extreme_tgt0: thresh=%0d, required 31", thresh_val);
        end
        run_search(255, 1'b0);
        n_tests++;
        if (thresh_val !== 5'd0) begin
            n_fail++;
            $display("FAIL extreme_tgt255: thresh=%0d, required 0", thresh_val);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) run_search(int'($urandom_range(0, 110)), 1'b0);
    endtask

    task automatic test_ignored_start();
        run_search(int'($urandom_range(20, 100)), 1'b1);
    endtask

    task automatic test_handoff();
        logic [4:0] v;
        logic       s;
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 5'd7 : 5'($urandom);
            s = (i == 0) ? 1'b1 : 1'($urandom);
            @(negedge clk);
            lf_ctrl = v;
            lf_sign = s;
            @(posedge clk);
            #1;
            n_tests++;
            if (ctrl !== v || ctrl_sign !== s) begin
                n_fail++;
                $display("FAIL handoff: ctrl=%0d sign=%b, required %0d %b", ctrl, ctrl_sign, v, s);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        target_cnt = 8'd55;
        kdco_cfg   = 5'd9;
        offset_cfg = 5'd3;
        start      = 1'b1;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (cyc == 700) reset = 1'b1;
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (thresh_val !== 5'd16 || kdco !== 5'd0 || dco_offset !== 5'd0 || ctrl !== 5'd0 || ctrl_sign !== 1'b0
            || busy !== 1'b0 || done !== 1'b0 || meas_cnt !== 8'd0 || lock_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: thresh=%0d kdco=%0d off=%0d ctrl=%0d busy=%b done=%b meas=%0d, required 16 0 0 0 0 0 0",
                     thresh_val, kdco, dco_offset, ctrl, busy, done, meas_cnt);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        run_search(55, 1'b0);
    endtask

    task automatic test_lockmon();
        run_search(55, 1'b0);
        repeat (2 * WIN + 10) @(posedge clk);
        #1;
        n_tests++;
        if (lock_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL lockmon_in_lock: lock_lost=%b, required 0", lock_lost);
        end
        n_override = 60;
        repeat (2 * WIN + 10) @(posedge clk);
        #1;
        n_tests++;
`ifdef DCO_CAL_LOCKMON_EN
        if (lock_lost !== 1'b1 || meas_cnt !== 8'd60) begin
            n_fail++;
            $display("FAIL lockmon_lost: lock_lost=%b meas=%0d, required 1 60", lock_lost, meas_cnt);
        end
`else
        if (lock_lost !== 1'b0 || meas_cnt !== 8'd55) begin
            n_fail++;
            $display("FAIL lockmon_off: lock_lost=%b meas=%0d, required 0 55", lock_lost, meas_cnt);
        end
`endif
        n_override = -1;
        repeat (WIN + 10) @(posedge clk);
        #1;
        n_tests++;
`ifdef DCO_CAL_LOCKMON_EN
        if (lock_lost !== 1'b1) begin
            n_fail++;
            $display("FAIL lockmon_sticky: lock_lost=%b, required 1", lock_lost);
        end
`else
        if (lock_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL lockmon_tied: lock_lost=%b, required 0", lock_lost);
        end
`endif
        run_search(55, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_handoff();
        test_extremes();
        test_random();
        test_ignored_start();
        test_reset_mid();
        test_lockmon();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dco_cal_ctrl.md
# dco_cal_ctrl

Coarse-calibration sequencer for `dco_5bit`. On `start`, it runs a 5-step successive-approximation search on the DCO's `thresh_val`, counting `dco_clk` rising edges over a fixed window of `clk` cycles at each step. It then hands the DCO's `ctrl`/`ctrl_sign` inputs over to the loop filter. It sits between the loop filter and the DCO, and owns every DCO configuration input.

## Interface
- `WIN_LEN`, default 255: measurement window length, in `clk` cycles (≥1).
- `SETTLE`, default 4: wait cycles after each code change before measuring (≥1).
- `CNT_W`, default 8: width of the edge counter and `target_cnt`.
- `clk`  in  1: system clock; also clocks the DCO.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle calibration request.
- `target_cnt`  in  CNT_W: desired `dco_clk` rising edges per window.
- `dco_clk`  in  1: DCO output, synchronous to `clk`.
- `kdco_cfg`  in  5: gain to apply to the DCO.
- `offset_cfg`  in  5: offset to apply to the DCO.
- `lf_ctrl`  in  5, `lf_sign`  in  1: loop-filter magnitude and sign.
- `thresh_val`  out  5: DCO threshold code.
- `kdco`  out  5, `dco_offset`  out  5: DCO gain and offset.
- `ctrl`  out  5, `ctrl_sign`  out  1: DCO control inputs.
- `busy`  out  1: calibration in progress.
- `done`  out  1: calibration complete; loop is closed.
- `meas_cnt`  out  CNT_W: edge count from the most recent window.
- `lock_lost`  out  1: lock monitor flag (see Configuration).

## Operation
- **States:** IDLE, SETTLE, MEASURE, DECIDE, LOCK.
- **Reset values:**
  - State IDLE.
  - `thresh_val`=16, `kdco`=0, `dco_offset`=0, `ctrl`=0, `ctrl_sign`=0.
  - `busy`=0, `done`=0, `meas_cnt`=0, `lock_lost`=0.
  - Bit index = 4. Edge counter = 0. Registered `dco_q`=0.
- **Start (IDLE or LOCK, `start`=1):**
  - `kdco`←`kdco_cfg`, `dco_offset`←`offset_cfg`, `thresh_val`←5'b10000, bit index←4.
  - `done`←0, `busy`←1, `lock_lost`←0. Go to SETTLE.
- **`start` while `busy`:** ignored.
- **SETTLE:** holds for SETTLE cycles, then goes to MEASURE with the edge counter cleared.
- **MEASURE:**
  - Lasts WIN_LEN cycles.
  - Edge = `dco_clk & ~dco_q`. `dco_q` registers `dco_clk` every cycle in all states.
  - The counter increments on each edge and saturates at 2^CNT_W−1.
  - Then go to DECIDE.
- **DECIDE (1 cycle):**
  - `meas_cnt`←count.
  - If count ≥ `target_cnt`, keep the current bit (DCO still too fast or on target); otherwise clear it.
  - If bit index > 0: set the next lower bit, decrement the index, go to SETTLE.
  - Otherwise go to LOCK.
- **Search result:** the largest code whose count is ≥ target, given that count is non-increasing in the code. Result is 0 if no code qualifies.
- **Outside LOCK:** `ctrl`=0 and `ctrl_sign`=0, so the DCO runs open-loop during calibration.
- **LOCK:**
  - `busy`=0, `done`=1.
  - `ctrl`/`ctrl_sign` register `lf_ctrl`/`lf_sign` every cycle (one-cycle latency).
  - `thresh_val`, `kdco` and `dco_offset` hold.
- **Reset mid-calibration:** all outputs return to their reset values on the next edge. The search does not resume.

## Timing
- `start` sampled at cycle 0 → `busy`=1 and `thresh_val`=16 from cycle 1.
- Each trial takes SETTLE+WIN_LEN+1 cycles. With defaults this is 260, with DECIDE at cycles 260·k for k=1..5.
- `done` rises at cycle 5·(SETTLE+WIN_LEN+1)+1; with defaults, cycle 1301.
- `thresh_val` changes only on the cycle after DECIDE, or on start/reset.
- `meas_cnt` updates on the cycle after DECIDE and is otherwise stable.

## Configuration
- **`DCO_CAL_LOCKMON_EN` defined:**
  - In LOCK, the block keeps running back-to-back windows of WIN_LEN cycles, updating `meas_cnt` after each.
  - `lock_lost` is set (sticky) when |count−`target_cnt`| > 2.
  - `lock_lost` clears only on reset or `start`. LOCK behaviour is otherwise unchanged.
- **Not defined:** no counting in LOCK; `meas_cnt` holds the final trial count and `lock_lost` is tied 0.

## Test plan
- **Nominal search:**
  - Stimulus: bench DCO stub produces 100−3·`thresh_val` edges per window; `target_cnt`=55; defaults.
  - Expected: `thresh_val` trial sequence 16, 8, 12, 14, 15; final 15; `meas_cnt`=55; `done` at cycle 1301.
- **Extremes:**
  - `target_cnt`=0 → final `thresh_val`=31.
  - `target_cnt`=255 → final `thresh_val`=0.
- **Handoff:**
  - Stimulus: in LOCK, drive `lf_ctrl`=7, `lf_sign`=1.
  - Expected: `ctrl`=7 and `ctrl_sign`=1 one cycle later. During calibration both read 0 regardless of `lf_*`.
- **Ignored start:** pulse `start` at cycle 500 → trial timing is unchanged and `done` still occurs at cycle 1301.
- **Reset mid-search:** assert `reset` at cycle 700 → all outputs at reset values next cycle. A new `start` reruns the full search.
- **Lock monitor (macro defined):** after lock, change the stub to give 60 edges → `lock_lost`=1 after the next window and stays set until `start`.
